bht_branch_predictor: RTL and testbench

//  Dynamic branch predictor for the 5-stage pipeline. Replaces the static always-not-taken scheme.

---
 rtl/bp_pkg.sv | 22 ++
 rtl/bp_counter_table.sv | 37 +++
 rtl/bht_branch_predictor.sv | 96 +++++++++
 tb/tb_bht_branch_predictor.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit counter encodings and the saturating update rule.
// Pure combinational helpers with no state.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    function automatic cnt_e sat_update(input cnt_e cnt, input logic taken);
        cnt_e r;
        if (taken) begin
            r = (cnt == ST) ? ST : cnt_e'(cnt + 2'd1);
        end else begin
            r = (cnt == SNT) ? SNT : cnt_e'(cnt - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// 2**IDX_W x 2-bit saturating counter array; zero-latency read, one read-modify-write port.
// A same-cycle update to the read index is bypassed so the reader sees the post-update value.
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int          IDX_W    = 6,
    parameter logic [1:0]  INIT_CNT = 2'b01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_upd_vld,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken,
    input  logic [IDX_W-1:0] i_rd_idx,
    output cnt_e             o_rd_cnt
);

    localparam int DEPTH = 1 << IDX_W;

    cnt_e r_cnt [DEPTH];
    cnt_e w_upd_cnt;

    assign w_upd_cnt = sat_update(r_cnt[i_upd_idx], i_upd_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_cnt[i] <= cnt_e'(INIT_CNT);
            end
        end else if (i_upd_vld) begin
            r_cnt[i_upd_idx] <= w_upd_cnt;
        end
    end

    assign o_rd_cnt = (i_upd_vld && (i_upd_idx == i_rd_idx)) ? w_upd_cnt : r_cnt[i_rd_idx];

endmodule

// File: rtl/bht_branch_predictor.sv
// 2-bit BHT predictor: combinational IF prediction/PC steering, ID resolve with redirect and training.
// stall freezes all state; BP_GSHARE_EN adds a global history XORed into the index.
module bht_branch_predictor
    import bp_pkg::*;
#(
    parameter int         IDX_W    = 6,
    parameter int         ADDR_LSB = 2,
    parameter logic [1:0] INIT_CNT = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_IF,
    input  logic [31:0] pc_IF,
    input  logic [31:0] PC_add_4,
    input  logic [31:0] PC_add_imm,
    input  logic        branch_ID,
    input  logic        jump_or_not,
    output logic [31:0] PC_out,
    output logic        correct,
    output logic        predict_jump
);

    logic [31:0]      r_add4_q;
    logic [31:0]      r_imm_q;
    logic             r_pred_q;
    logic [IDX_W-1:0] r_idx_q;

    logic [IDX_W-1:0] w_idx;
    cnt_e             w_cnt;
    logic             w_pred;
    logic             w_resolve;
    logic             w_mispredict;
    logic             w_fetch;
    logic             w_if_taken;
    logic             w_unused;

    assign w_unused = ^{pc_IF[31:ADDR_LSB+IDX_W], pc_IF[ADDR_LSB-1:0]};

    // Resolution is suppressed while reset is held so correct stays high.
    assign w_resolve    = branch_ID & ~stall & rst_n;
    assign w_mispredict = w_resolve & (jump_or_not ^ r_pred_q);
    assign w_fetch      = branch_IF & ~stall & ~w_mispredict;
    assign w_pred       = (w_cnt == WT) || (w_cnt == ST);
    assign w_if_taken   = branch_IF & ~w_mispredict & w_pred;

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] r_ghr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ghr <= '0;
        end else if (w_resolve) begin
            r_ghr <= {r_ghr[IDX_W-2:0], jump_or_not};
        end
    end

    assign w_idx = pc_IF[ADDR_LSB +: IDX_W] ^ r_ghr;
`else
    assign w_idx = pc_IF[ADDR_LSB +: IDX_W];
`endif

    bp_counter_table #(
        .IDX_W    (IDX_W),
        .INIT_CNT (INIT_CNT)
    ) u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_upd_vld   (w_resolve),
        .i_upd_idx   (r_idx_q),
        .i_upd_taken (jump_or_not),
        .i_rd_idx    (w_idx),
        .o_rd_cnt    (w_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_add4_q <= '0;
            r_imm_q  <= '0;
            r_pred_q <= 1'b0;
            r_idx_q  <= '0;
        end else if (w_fetch) begin
            r_add4_q <= PC_add_4;
            r_imm_q  <= PC_add_imm;
            r_pred_q <= w_pred;
            r_idx_q  <= w_idx;
        end
    end

    // A mispredict redirects to the path the ID branch did not predict.
    assign PC_out       = w_mispredict ? (r_pred_q ? r_add4_q : r_imm_q)
                                       : (w_if_taken ? PC_add_imm : PC_add_4);
    assign correct      = ~w_mispredict;
    assign predict_jump = w_fetch & w_pred;

endmodule

// File: tb/tb_bht_branch_predictor.sv
// Directed bench for bht_branch_predictor with a per-cycle counter-table model and literal spot checks.
module tb_bht_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall, branch_IF, branch_ID, jump_or_not;
    logic [31:0] pc_IF, PC_add_4, PC_add_imm;
    logic [31:0] PC_out;
    logic        correct, predict_jump;

    always #5 clk = ~clk;

    bht_branch_predictor #(
        .IDX_W    (6),
        .ADDR_LSB (2),
        .INIT_CNT (2'b01)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_IF    (branch_IF),
        .pc_IF        (pc_IF),
        .PC_add_4     (PC_add_4),
        .PC_add_imm   (PC_add_imm),
        .branch_ID    (branch_ID),
        .jump_or_not  (jump_or_not),
        .PC_out       (PC_out),
        .correct      (correct),
        .predict_jump (predict_jump)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: counters as plain integers 0..3, in-flight branch as a record of what IF saw.
    int          m_cnt [64];
    bit          m_pred_q;
    logic [31:0] m_add4_q, m_imm_q;
    int          m_idx_q;
    int          m_ghr;

    bit          p_res, p_fetch, p_pred, p_jump;
    int          p_newv, p_fidx;
    logic [31:0] p_add4, p_imm;

    bit          e_mis, e_pj, e_if_taken;
    int          e_c, e_old;
    logic [31:0] e_pc;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_cnt[i] = 1;
        m_pred_q = 1'b0;
        m_add4_q = '0;
        m_imm_q  = '0;
        m_idx_q  = 0;
        m_ghr    = 0;
        p_res    = 1'b0;
        p_fetch  = 1'b0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        if (chk_en) begin
            p_res  = branch_ID && !stall && rst_n;
            p_jump = jump_or_not;
            e_mis  = p_res && (jump_or_not != m_pred_q);
            e_old  = m_cnt[m_idx_q];
            p_newv = jump_or_not ? ((e_old == 3) ? 3 : e_old + 1) : ((e_old == 0) ? 0 : e_old - 1);
`ifdef BP_GSHARE_EN
            p_fidx = ((pc_IF >> 2) % 64) ^ m_ghr;
`else
            p_fidx = (pc_IF >> 2) % 64;
`endif
            e_c        = (p_res && p_fidx == m_idx_q) ? p_newv : m_cnt[p_fidx];
            p_pred     = (e_c >= 2);
            p_fetch    = branch_IF && !stall && !e_mis;
            p_add4     = PC_add_4;
            p_imm      = PC_add_imm;
            e_pj       = p_fetch && p_pred;
            e_if_taken = branch_IF && !e_mis && p_pred;
            if (e_mis) e_pc = m_pred_q ? m_add4_q : m_imm_q;
            else       e_pc = e_if_taken ? PC_add_imm : PC_add_4;
            chk("model_correct", {31'd0, correct}, {31'd0, !e_mis});
            chk("model_predict_jump", {31'd0, predict_jump}, {31'd0, e_pj});
            chk("model_PC_out", PC_out, e_pc);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            if (p_res) begin
                m_cnt[m_idx_q] = p_newv;
                m_ghr = ((m_ghr << 1) | int'(p_jump)) % 64;
            end
            if (p_fetch) begin
                m_pred_q = p_pred;
                m_add4_q = p_add4;
                m_imm_q  = p_imm;
                m_idx_q  = p_fidx;
            end
            p_res   = 1'b0;
            p_fetch = 1'b0;
        end
    end

    task automatic cyc(input bit bif, input logic [31:0] pc, input logic [31:0] imm,
                       input bit bid, input bit jmp, input bit stl);
        @(posedge clk);
        #1;
        branch_IF   = bif;
        pc_IF       = pc;
        PC_add_4    = pc + 32'd4;
        PC_add_imm  = imm;
        branch_ID   = bid;
        jump_or_not = jmp;
        stall       = stl;
        #2;
    endtask

    task automatic fetch40();
        cyc(1'b1, 32'h40, 32'h80, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resolve(input bit jmp);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, jmp, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        stall = 0; branch_IF = 0; branch_ID = 0; jump_or_not = 0;
        pc_IF = 32'h40; PC_add_4 = 32'h44; PC_add_imm = 32'h80;
        chk_en = 1'b1;
        #1 rst_n = 1'b0;

        // Reset held, with a resolve request that must be ignored.
        cyc(1'b0, 32'h40, 32'h80, 1'b1, 1'b1, 1'b0);
        chk("rst_correct", {31'd0, correct}, 32'd1);
        chk("rst_predict_jump", {31'd0, predict_jump}, 32'd0);
        chk("rst_PC_out", PC_out, 32'h44);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: first fetch predicts not-taken, taken resolve redirects to target.
        fetch40();
        chk("t1_fetch_pj", {31'd0, predict_jump}, 32'd0);
        chk("t1_fetch_pc", PC_out, 32'h44);
        resolve(1'b1);
        chk("t1_res_correct", {31'd0, correct}, 32'd0);
        chk("t1_res_pc", PC_out, 32'h80);

        // 2: counter now WT; fetch predicts taken; collision resolve+fetch on same index.
        fetch40();
        chk("t2_fetch_pj", {31'd0, predict_jump}, 32'd1);
        chk("t2_fetch_pc", PC_out, 32'h80);
        cyc(1'b1, 32'h40, 32'h80, 1'b1, 1'b1, 1'b0);
        chk("t2_coll_correct", {31'd0, correct}, 32'd1);
        chk("t2_coll_pj", {31'd0, predict_jump}, 32'd1);
        resolve(1'b1);
        chk("t2_res_correct", {31'd0, correct}, 32'd1);
        fetch40();
        resolve(1'b1);
        chk("t2_st_correct", {31'd0, correct}, 32'd1);

        // 3: ST, resolve not-taken -> fall-through redirect; WT still predicts taken.
        fetch40();
        chk("t3_fetch_pj", {31'd0, predict_jump}, 32'd1);
        resolve(1'b0);
        chk("t3_res_correct", {31'd0, correct}, 32'd0);
        chk("t3_res_pc", PC_out, 32'h44);
        fetch40();
        chk("t3_wt_pj", {31'd0, predict_jump}, 32'd1);
        chk("t3_wt_pc", PC_out, 32'h80);

        // 4: mispredict with a simultaneous IF branch at 0x84; IF branch is flushed.
        cyc(1'b1, 32'h84, 32'h200, 1'b1, 1'b0, 1'b0);
        chk("t4_correct", {31'd0, correct}, 32'd0);
        chk("t4_pc", PC_out, 32'h44);
        chk("t4_pj", {31'd0, predict_jump}, 32'd0);
        resolve(1'b0);
        chk("t4_latch_kept_correct", {31'd0, correct}, 32'd0);
        chk("t4_latch_kept_pc", PC_out, 32'h44);

        // 5: stalled resolve is ignored, then evaluated once after stall drops.
        fetch40();
        chk("t5_fetch_pj", {31'd0, predict_jump}, 32'd0);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("t5_stall_correct", {31'd0, correct}, 32'd1);
        chk("t5_stall_pc", PC_out, 32'h4);
        resolve(1'b1);
        chk("t5_res_correct", {31'd0, correct}, 32'd0);
        chk("t5_res_pc", PC_out, 32'h80);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("t5_idle_correct", {31'd0, correct}, 32'd1);
        fetch40();
        chk("t5_nochange_pj", {31'd0, predict_jump}, 32'd0);
        resolve(1'b1);

        // Async reset mid-resolve: counters go back to WNT at once.
        fetch40();
        resolve(1'b1);
        fetch40();
        chk("pre_rst_pj", {31'd0, predict_jump}, 32'd1);
        cyc(1'b1, 32'h40, 32'h80, 1'b1, 1'b1, 1'b0);
        chk("pre_rst_coll_pj", {31'd0, predict_jump}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_correct", {31'd0, correct}, 32'd1);
        chk("mid_rst_pj", {31'd0, predict_jump}, 32'd0);
        chk("mid_rst_pc", PC_out, 32'h44);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        fetch40();
        chk("post_rst_pj", {31'd0, predict_jump}, 32'd0);
        resolve(1'b0);
        chk("post_rst_correct", {31'd0, correct}, 32'd1);

        // 6: two PCs sharing a PC index, trained opposite ways.
        for (int i = 0; i < 10; i++) begin
            fetch40();
            resolve(1'b1);
`ifdef BP_GSHARE_EN
            if (i >= 5) chk("t6_a_correct", {31'd0, correct}, 32'd1);
`endif
            cyc(1'b1, 32'h140, 32'h300, 1'b0, 1'b0, 1'b0);
            resolve(1'b0);
`ifdef BP_GSHARE_EN
            if (i >= 5) chk("t6_b_correct", {31'd0, correct}, 32'd1);
`endif
        end

        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
